iob_timer_sched: RTL

IOB_TIMER_SCHED -- requirements
Module: iob_timer_sched

---
 rtl/iob_timer_sched_pkg.sv | 20 ++
 rtl/iob_timer_sched_ch.sv | 74 +++++++
 rtl/iob_timer_sched.sv | 86 ++++++++
 3 files changed

// File: rtl/iob_timer_sched_pkg.sv
// rtl/iob_timer_sched_pkg.sv - register map, bit positions and channel state encoding
package iob_timer_sched_pkg;

  localparam logic [1:0] REG_CMP_LO = 2'd0;
  localparam logic [1:0] REG_CMP_HI = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int STATUS_FIRED = 0;
  localparam int STATUS_ARMED = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } ch_state_e;

endpackage

// File: rtl/iob_timer_sched_ch.sv
// rtl/iob_timer_sched_ch.sv - one alarm channel: deadline registers, control bits and state machine
module iob_timer_sched_ch
  import iob_timer_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_sel,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  input  logic        scan_hit,
  output logic [63:0] deadline,
  output logic        en,
  output logic        irq_en,
  output logic        fired,
  output logic        armed,
  output logic        irq
);

  ch_state_e   state_q, state_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] shadow_lo_q;
  logic [63:0] deadline_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      shadow_lo_q <= '0;
      deadline_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      if (wr_sel && reg_sel == REG_CMP_LO) shadow_lo_q <= wdata;
      if (wr_sel && reg_sel == REG_CMP_HI) deadline_q  <= {wdata, shadow_lo_q};
    end
  end

  // Any CPU write to this channel suppresses the scan result of the same cycle.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (wr_sel) begin
      case (reg_sel)
        REG_CTRL: begin
          en_d     = wdata[CTRL_EN];
          irq_en_d = wdata[CTRL_IRQ_EN];
          if (!wdata[CTRL_EN])          state_d = ST_IDLE;
          else if (state_q == ST_IDLE)  state_d = ST_ARMED;
        end
        REG_STATUS: begin
          if (wdata[STATUS_FIRED] && state_q == ST_FIRED) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (scan_hit && state_q == ST_ARMED) begin
      state_d = ST_FIRED;
    end
  end

  assign deadline = deadline_q;
  assign en       = en_q;
  assign irq_en   = irq_en_q;
  assign fired    = (state_q == ST_FIRED);
  assign armed    = (state_q == ST_ARMED);
  assign irq      = fired & irq_en_q;

endmodule

// File: rtl/iob_timer_sched.sv
// rtl/iob_timer_sched.sv - multi-channel alarm scheduler sharing one 64-bit comparator round-robin
module iob_timer_sched
  import iob_timer_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       cnt,
  input  logic              valid,
  input  logic              wr,
  input  logic [CH_W+1:0]   addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              ready,
  output logic [N_CH-1:0]   irq,
  output logic              irq_any
);

  logic [CH_W-1:0] slot_q;
  logic [CH_W-1:0] req_ch;
  logic [1:0]      req_reg;
  logic [63:0]     dl [N_CH];
  logic [N_CH-1:0] en, irq_en, fired, armed;
  logic            cmp_ge;
  logic [31:0]     rd_data;

  assign req_ch  = addr[CH_W+1:2];
  assign req_reg = addr[1:0];
  assign cmp_ge  = (cnt >= dl[slot_q]);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_sel;
    logic scan_hit;
    assign wr_sel   = valid & wr & (req_ch == CH_W'(i));
    assign scan_hit = cmp_ge & (slot_q == CH_W'(i));

    iob_timer_sched_ch u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_sel   (wr_sel),
      .reg_sel  (req_reg),
      .wdata    (data_in),
      .scan_hit (scan_hit),
      .deadline (dl[i]),
      .en       (en[i]),
      .irq_en   (irq_en[i]),
      .fired    (fired[i]),
      .armed    (armed[i]),
      .irq      (irq[i])
    );
  end

  always_comb begin
    rd_data = '0;
    case (req_reg)
      REG_CMP_LO: rd_data = dl[req_ch][31:0];
      REG_CMP_HI: rd_data = dl[req_ch][63:32];
      REG_CTRL: begin
        rd_data[CTRL_EN]     = en[req_ch];
        rd_data[CTRL_IRQ_EN] = irq_en[req_ch];
      end
      default: begin
        rd_data[STATUS_FIRED] = fired[req_ch];
        rd_data[STATUS_ARMED] = armed[req_ch];
      end
    endcase
  end

  // N_CH is a power of two, so the slot counter wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= '0;
      ready    <= 1'b0;
      data_out <= '0;
    end else begin
      slot_q <= slot_q + CH_W'(1);
      ready  <= valid;
      if (valid && !wr) data_out <= rd_data;
    end
  end

  assign irq_any = |irq;

endmodule
